restoring_divider_8: RTL and testbench

- Sequential unsigned restoring divider.
- Computes quotient and remainder of an 8-bit dividend by an 8-bit divisor with one trial subtraction per clock.
- Inverse operation to the adder/multiplier datapaths in the arithmetic library.
- The trial subtraction uses the same ripple-carry structure as the adders: invert the subtrahend, carry-in = 1.
- Sits beside the multipliers as the library's iterative divide unit, with a start/done handshake.

---
 rtl/divider_pkg.sv | 28 ++
 rtl/restoring_divider_8_trial_subtractor.sv | 34 +++
 rtl/restoring_divider_8.sv | 150 +++++++++++++++
 tb/tb_restoring_divider_8.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
`default_nettype none
// ============================================================================
// Module      : divider_pkg
// Description : Shared types and constants for the iterative restoring divider.
// Revision    : 1.0 - initial release
// ============================================================================
package divider_pkg;

  // Default operand/result width of the divide unit.
  localparam int DEF_WIDTH = 8;

  // Iteration counter width at the default width: must hold the value WIDTH.
  localparam int DEF_CNT_W = $clog2(DEF_WIDTH + 1);

  // Control states of the divider.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width needed to hold the value w.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage : divider_pkg
`default_nettype wire

// File: rtl/restoring_divider_8_trial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : trial_subtractor
// Description : Combinational (WIDTH+1)-bit ripple-carry subtractor built from
//               full-adder cells: diff = a + ~b + 1, borrow = ~carry_out.
// Revision    : 1.0 - initial release
// ============================================================================
module trial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  output logic [WIDTH:0] diff,
  output logic           borrow
);

  logic [WIDTH:0]   b_inv;
  logic [WIDTH+1:0] carry;

  // Two's-complement subtraction: invert the subtrahend, carry-in of one.
  assign b_inv    = ~b;
  assign carry[0] = 1'b1;

  // One full-adder cell per bit, carries rippling from LSB to MSB.
  for (genvar i = 0; i <= WIDTH; i++) begin : g_bit
    assign diff[i]    = a[i] ^ b_inv[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b_inv[i]) | (a[i] & carry[i]) | (b_inv[i] & carry[i]);
  end

  // No carry out of the top cell means a < b.
  assign borrow = ~carry[WIDTH+1];

endmodule : trial_subtractor
`default_nettype wire

// File: rtl/restoring_divider_8.sv
`default_nettype none
// ============================================================================
// Module      : restoring_divider_8
// Description : Sequential unsigned restoring divider, one trial subtraction
//               per clock, start/done handshake. Divide-by-zero returns
//               quotient = all ones, remainder = dividend, div_by_zero = 1.
// Revision    : 1.0 - initial release
// ============================================================================
module restoring_divider_8
  import divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t state, state_next;

  // Working registers: partial remainder, quotient/dividend shift register,
  // latched divisor and iteration counter.
  logic [WIDTH-1:0] rem, rem_next;
  logic [WIDTH-1:0] quo, quo_next;
  logic [WIDTH-1:0] dvs, dvs_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  // Next values of the held result outputs.
  logic [WIDTH-1:0] quotient_next;
  logic [WIDTH-1:0] remainder_next;
  logic             div_by_zero_next;

  // Trial subtraction operands. The partial remainder after the left shift
  // keeps the bit shifted out of rem as its MSB, so divisors above half
  // range are handled without losing that bit.
  logic [WIDTH:0] part;
  logic [WIDTH:0] diff;
  logic           borrow;
  logic           take;

  assign part = {rem, quo[WIDTH-1]};

  trial_subtractor #(
    .WIDTH (WIDTH)
  ) u_trial_subtractor (
    .a      (part),
    .b      ({1'b0, dvs}),
    .diff   (diff),
    .borrow (borrow)
  );

  // Subtraction is kept when the result is non-negative; since the partial
  // remainder never reaches twice the divisor, it then also fits in WIDTH bits.
  assign take = ~borrow & ~diff[WIDTH];

  // Handshake outputs decode directly from the state.
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      rem         <= rem_next;
      quo         <= quo_next;
      dvs         <= dvs_next;
      cnt         <= cnt_next;
      quotient    <= quotient_next;
      remainder   <= remainder_next;
      div_by_zero <= div_by_zero_next;
    end
  end

  // Next-state, iteration step and result capture on entry to DONE.
  always_comb begin
    state_next       = state;
    rem_next         = rem;
    quo_next         = quo;
    dvs_next         = dvs;
    cnt_next         = cnt;
    quotient_next    = quotient;
    remainder_next   = remainder;
    div_by_zero_next = div_by_zero;

    case (state)
      IDLE, DONE: begin
        // DONE lasts one cycle; both states accept a new request.
        state_next = IDLE;
        if (start) begin
          dvs_next = divisor;
          rem_next = '0;
          quo_next = dividend;
          cnt_next = CNT_W'(WIDTH);
          if (divisor == '0) begin
            state_next       = DONE;
            quotient_next    = '1;
            remainder_next   = dividend;
            div_by_zero_next = 1'b1;
          end else begin
            state_next = RUN;
          end
        end
      end

      RUN: begin
        // Shift {rem, quo} left, trial subtract, restore on borrow.
        rem_next = take ? diff[WIDTH-1:0] : part[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], take};
        cnt_next = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_next       = DONE;
          quotient_next    = {quo[WIDTH-2:0], take};
          remainder_next   = take ? diff[WIDTH-1:0] : part[WIDTH-1:0];
          div_by_zero_next = 1'b0;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule : restoring_divider_8
`default_nettype wire

// File: tb/tb_restoring_divider_8.sv
`default_nettype none
// ============================================================================
// Module      : tb_restoring_divider_8
// Description : Scoreboard bench for restoring_divider_8 with directed edge
//               cases and randomized operands against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_restoring_divider_8;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           issue;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  exp_t sb[$];

  restoring_divider_8 #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain unsigned division, all-ones/dividend for zero.
  function automatic exp_t model(input int a, input int b, input int issue);
    exp_t e;
    if (b == 0) begin
      e.q = '1; e.r = W'(a); e.dbz = 1'b1; e.lat = 1;
    end else begin
      e.q = W'(a / b); e.r = W'(a % b); e.dbz = 1'b0; e.lat = W + 1;
    end
    e.issue = issue;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", div_by_zero, e.dbz);
        chk("latency", cyc - e.issue, e.lat);
        chk("busy_at_done", busy, 0);
      end
    end
  end

  // Raise start for one cycle with the given operands and record the expectation.
  task automatic issue(input int a, input int b);
    @(posedge clk); #1;
    dividend = W'(a);
    divisor  = W'(b);
    start    = 1'b1;
    sb.push_back(model(a, b, cyc));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Wait (bounded) for a done pulse, sampled at the falling edge.
  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic run_op(input int a, input int b);
    issue(a, b);
    wait_done();
  endtask

  initial begin
    // Reset state.
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    @(negedge clk); rst_n = 1'b1;

    // Basic divide with busy profile over cycles 1..8.
    issue(200, 7);
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      chk("busy_run", busy, 1);
      chk("no_early_done", done, 0);
    end
    wait_done();

    // Edge values.
    run_op(255, 1);
    run_op(5, 9);
    run_op(255, 255);
    run_op(0, 13);
    run_op(200, 201);
    run_op(254, 255);

    // Divide by zero, then recovery of the flag.
    run_op(77, 0);
    run_op(10, 3);

    // Busy-time disturbance: second start and operand changes are ignored.
    issue(100, 9);
    repeat (2) @(posedge clk);
    #1; dividend = 8'd50; divisor = 8'd5; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; dividend = 8'd3; divisor = 8'd0;
    wait_done();
    repeat (12) @(negedge clk);
    chk("disturb_single_done", sb.size(), 0);

    // Back-to-back with start held high.
    @(posedge clk); #1;
    dividend = 8'd200; divisor = 8'd7; start = 1'b1;
    sb.push_back(model(200, 7, cyc));
    wait_done();
    dividend = 8'd9; divisor = 8'd2;
    sb.push_back(model(9, 2, cyc));
    @(posedge clk); #1; start = 1'b0;
    wait_done();

    // Reset in the middle of an operation.
    issue(200, 7);
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b0;
    void'(sb.pop_back());
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    chk("abort_dbz", div_by_zero, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(60, 8);

    // Randomized operands, some with a zero divisor.
    for (int n = 0; n < 60; n++) begin
      int a, b;
      a = int'($urandom_range(0, 255));
      b = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 255));
      run_op(a, b);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_restoring_divider_8
`default_nettype wire
